// File: rtl/rs_strobe_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// rs_strobe_sequencer : turns hold/set/reset/toggle commands into timed R/S/enable strobes
//                       for an RS flip-flop and confirms the result by reading Q back.
// Revision: 1.0
// ============================================================================
module rs_strobe_sequencer #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       q_in,
  output logic       R,
  output logic       S,
  output logic       enable,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    CHECK  = 3'd4
  } state_t;

  localparam logic [7:0] C_SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] C_PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] C_HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_lat_r, r_lat_s, r_exp;
  logic       w_lat_r_nxt, w_lat_s_nxt, w_exp_nxt;
  logic       w_accept, w_drive, w_done_nxt, w_err_nxt;

  assign cmd_ready = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat_r_nxt = r_lat_r;
    w_lat_s_nxt = r_lat_s;
    w_exp_nxt   = r_exp;
    w_done_nxt  = 1'b0;
    w_err_nxt   = err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = C_SETUP_LOAD;
          // toggle drives the pair from the current Q so R and S stay exclusive
          case (cmd)
            2'b00: begin w_lat_r_nxt = 1'b0; w_lat_s_nxt = 1'b0;  w_exp_nxt = q_in;  end
            2'b01: begin w_lat_r_nxt = 1'b0; w_lat_s_nxt = 1'b1;  w_exp_nxt = 1'b1;  end
            2'b10: begin w_lat_r_nxt = 1'b1; w_lat_s_nxt = 1'b0;  w_exp_nxt = 1'b0;  end
            2'b11: begin w_lat_r_nxt = q_in; w_lat_s_nxt = ~q_in; w_exp_nxt = ~q_in; end
          endcase
        end
      end
      SETUP: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = C_PULSE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      STROBE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = C_HOLD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      HOLD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = CHECK;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = (q_in != r_exp);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // outputs are registered from the next state so R/S only move on SETUP entry and HOLD exit
  assign w_drive = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) || (w_state_nxt == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_lat_r <= 1'b0;
      r_lat_s <= 1'b0;
      r_exp   <= 1'b0;
      R       <= 1'b0;
      S       <= 1'b0;
      enable  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lat_r <= w_lat_r_nxt;
      r_lat_s <= w_lat_s_nxt;
      r_exp   <= w_exp_nxt;
      R       <= w_drive && w_lat_r_nxt;
      S       <= w_drive && w_lat_s_nxt;
      enable  <= (w_state_nxt == STROBE);
      done    <= w_done_nxt;
      err     <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_strobe_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_rs_strobe_sequencer : checks rs_strobe_sequencer with default timing (dut 0)
//                          and 3/1/2 timing (dut 1) against an RS flip-flop model.
// Revision: 1.0
// ============================================================================
module tb_rs_strobe_sequencer;

  typedef struct {
    int   dut;
    logic exp_err;
    int   acc_edge;
  } sb_t;

  typedef struct {
    logic [1:0] c;
    logic       fe;
    logic       fv;
    logic       eq;
    logic       ee;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       valid   [2];
  logic [1:0] cmd     [2];
  logic       ready   [2];
  logic       q       [2];
  logic       R       [2];
  logic       S       [2];
  logic       en      [2];
  logic       busy    [2];
  logic       done    [2];
  logic       err     [2];
  logic       frc     [2];
  logic       frc_val [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;
  int   last_acc [2];
  int   prev_acc [2];
  logic rst_last = 1'b1;
  int   rs_viol = 0;
  int   stab_viol = 0;
  sb_t  sb [$];

  rs_strobe_sequencer u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(valid[0]), .cmd(cmd[0]), .cmd_ready(ready[0]),
    .q_in(q[0]), .R(R[0]), .S(S[0]), .enable(en[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  rs_strobe_sequencer #(.SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(valid[1]), .cmd(cmd[1]), .cmd_ready(ready[1]),
    .q_in(q[1]), .R(R[1]), .S(S[1]), .enable(en[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  // flip-flop model; a forced q_in disconnects it
  for (genvar g = 0; g < 2; g++) begin : g_ff
    logic q_r = 1'b0;
    always @(posedge clk) begin
      if (!frc[g] && en[g]) begin
        if (S[g]) q_r <= 1'b1;
        else if (R[g]) q_r <= 1'b0;
      end
    end
    assign q[g] = frc[g] ? frc_val[g] : q_r;
  end

  function automatic logic exp_val(input logic [1:0] c, input logic qv);
    case (c)
      2'b00:   return qv;
      2'b01:   return 1'b1;
      2'b10:   return 1'b0;
      default: return ~qv;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // accept recorder: pushes the expected readback result at each accepting edge
  initial begin
    sb_t ne;
    logic ev;
    last_acc = '{-100, -100};
    prev_acc = '{-100, -100};
    forever begin
      @(posedge clk);
      edge_n++;
      for (int d = 0; d < 2; d++) begin
        if (valid[d] && ready[d]) begin
          ev          = exp_val(cmd[d], q[d]);
          ne.dut      = d;
          ne.exp_err  = frc[d] ? (frc_val[d] != ev) : 1'b0;
          ne.acc_edge = edge_n;
          sb.push_back(ne);
          prev_acc[d] = last_acc[d];
          last_acc[d] = edge_n;
        end
      end
      if (reset) sb.delete();
      rst_last = reset;
    end
  end

  // per-DUT monitor: R/S exclusivity, stability around enable, pulse width, done latency, err
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int GN  = (g == 0) ? 5 : 7;
    localparam int GPW = (g == 0) ? 2 : 1;
    initial begin
      int   run;
      logic pR, pS, pen;
      sb_t  e;
      run = 0; pR = 1'b0; pS = 1'b0; pen = 1'b0;
      forever begin
        @(negedge clk);
        rs_excl: assert (!(R[g] && S[g])) else rs_viol++;
        if (!rst_last && (pen || en[g]) && (R[g] !== pR || S[g] !== pS)) stab_viol++;
        if (en[g]) begin
          run++;
        end else if (pen) begin
          if (!rst_last) chk($sformatf("enable_width_d%0d", g), run, GPW);
          run = 0;
        end
        if (done[g]) begin
          if (sb.size() == 0 || sb[0].dut != g) begin
            chk($sformatf("done_unexpected_d%0d", g), int'(done[g]), 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("done_latency_d%0d", g), edge_n - e.acc_edge, GN);
            chk($sformatf("err_d%0d", g), int'(err[g]), int'(e.exp_err));
          end
        end
        pR = R[g]; pS = S[g]; pen = en[g];
      end
    end
  end

  task automatic send(input int d, input logic [1:0] c);
    int k = 0;
    while (!ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready[d]) chk($sformatf("send_ready_timeout_d%0d", d), int'(ready[d]), 1);
    valid[d] = 1'b1;
    cmd[d]   = c;
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done[d] && k < 40);
    if (!done[d]) chk($sformatf("done_timeout_d%0d", d), int'(done[d]), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_seq [6];
    vec_t       tbl [8];
    logic       prev_err;
    logic       bq;
    logic [1:0] c;
    int         cnt;

    exp_seq = '{4'b0100, 4'b0110, 4'b0110, 4'b0100, 4'b0000, 4'b0001};
    tbl[0] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; cmd[d] = 2'b00; frc[d] = 1'b0; frc_val[d] = 1'b0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_d%0d", d), int'(ready[d]), 0);
      chk($sformatf("rst_outs_d%0d", d), int'({R[d], S[d], en[d], busy[d], done[d], err[d]}), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(ready[0]), 1);

    // set: cycle-by-cycle strobe shape {R,S,enable,done}
    send(0, 2'b01);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk($sformatf("set_shape_j%0d", j), int'({R[0], S[0], en[0], done[0]}), int'(exp_seq[j]));
    end
    chk("set_err", int'(err[0]), 0);
    chk("set_q", int'(q[0]), 1);
    prev_err = 1'b0;

    // vector table, each accepted on the previous done cycle
    for (int i = 0; i < 8; i++) begin
      frc[0]     = tbl[i].fe;
      frc_val[0] = tbl[i].fv;
      send(0, tbl[i].c);
      chk($sformatf("accept_gap_%0d", i), last_acc[0] - prev_acc[0], 6);
      chk($sformatf("err_held_%0d", i), int'(err[0]), int'(prev_err));
      wait_done(0);
      chk($sformatf("vec_q_%0d", i), int'(q[0]), int'(tbl[i].eq));
      chk($sformatf("vec_err_%0d", i), int'(err[0]), int'(tbl[i].ee));
      prev_err = tbl[i].ee;
    end

    // reset command offered mid-STROBE of a set is ignored
    send(0, 2'b01);
    @(negedge clk);
    @(negedge clk);
    valid[0] = 1'b1;
    cmd[0]   = 2'b10;
    chk("busy_in_strobe", int'(busy[0]), 1);
    chk("ready_in_strobe", int'(ready[0]), 0);
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (R[0]) cnt++;
    end
    valid[0] = 1'b0;
    wait_done(0);
    chk("ignored_R_low", cnt, 0);
    chk("ignored_q", int'(q[0]), 1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done[0]) cnt++;
    end
    chk("ignored_single_done", cnt, 0);

    // one-cycle reset in the middle of STROBE aborts without done
    send(0, 2'b10);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_enable_before", int'(en[0]), 1);
    chk("abort_ready_in_reset", int'(ready[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_outs", int'({R[0], S[0], en[0], busy[0], done[0]}), 0);
    chk("abort_ready_after", int'(ready[0]), 1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[0]) cnt++;
    end
    chk("abort_no_done", cnt, 0);

    // 3/1/2 timing with random commands
    bq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c = 2'($urandom_range(0, 3));
      bq = exp_val(c, bq);
      send(1, c);
      wait_done(1);
      chk($sformatf("rand_q_%0d", i), int'(q[1]), int'(bq));
    end

    repeat (3) @(negedge clk);
    chk("rs_never_both", rs_viol, 0);
    chk("rs_stable_around_enable", stab_viol, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
